// File: rtl/crossbar_pkg.sv
// Shared constants and helpers for the buffered N x M crossbar.
// Control fields are packed with output 0 in the MSBs.
package crossbar_pkg;

    localparam int XBAR_CNT_W = 16;

    typedef logic [XBAR_CNT_W-1:0] xfer_cnt_t;

    // LSB position of output k's {en, sel} field inside the control word.
    function automatic int ctrl_field_lsb(input int k, input int n_outputs, input int sel_w);
        return (n_outputs - 1 - k) * (sel_w + 1);
    endfunction

endpackage

// File: rtl/crossbar_nxm_buffered_if.sv
// Val/rdy bundle for the buffered crossbar: receive side, send side and control.
// Optional macro XBAR_PERF_CNT_EN adds the per-output xfer_cnt bus.
interface crossbar_nxm_buffered_if #(
    parameter int BIT_WIDTH = 32,
    parameter int N_INPUTS  = 4,
    parameter int N_OUTPUTS = 4
) ();
    localparam int SEL_W             = $clog2(N_INPUTS);
    localparam int CONTROL_BIT_WIDTH = N_OUTPUTS * (SEL_W + 1);

    logic [BIT_WIDTH-1:0]         recv_msg [N_INPUTS];
    logic [N_INPUTS-1:0]          recv_val;
    logic [N_INPUTS-1:0]          recv_rdy;
    logic [BIT_WIDTH-1:0]         send_msg [N_OUTPUTS];
    logic [N_OUTPUTS-1:0]         send_val;
    logic [N_OUTPUTS-1:0]         send_rdy;
    logic [CONTROL_BIT_WIDTH-1:0] control;
    logic                         control_val;
    logic                         control_rdy;
`ifdef XBAR_PERF_CNT_EN
    crossbar_pkg::xfer_cnt_t      xfer_cnt [N_OUTPUTS];
`endif

    // Environment side: produces messages and control, consumes outputs.
    modport master (
        output recv_msg, recv_val, send_rdy, control, control_val,
`ifdef XBAR_PERF_CNT_EN
        input  xfer_cnt,
`endif
        input  recv_rdy, send_msg, send_val, control_rdy
    );

    // Crossbar side.
    modport slave (
        input  recv_msg, recv_val, send_rdy, control, control_val,
`ifdef XBAR_PERF_CNT_EN
        output xfer_cnt,
`endif
        output recv_rdy, send_msg, send_val, control_rdy
    );

endinterface

// File: rtl/xbar_out_fifo2.sv
// Two-entry val/rdy FIFO decoupling one crossbar output; head is driven from storage.
// Enqueue into a full FIFO is accepted only when the head leaves in the same cycle.
module xbar_out_fifo2 #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enq_val_i,
    input  logic [W-1:0] enq_msg_i,
    input  logic         deq_rdy_i,
    output logic [W-1:0] deq_msg_o,
    output logic         full_o,
    output logic         empty_o,
    output logic         deq_fire_o
);
    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         enq_fire;

    assign empty_o    = (cnt_q == 2'd0);
    assign full_o     = (cnt_q == 2'd2);
    assign deq_fire_o = !empty_o && deq_rdy_i;
    assign enq_fire   = enq_val_i && (!full_o || deq_fire_o);
    assign deq_msg_o  = mem_q[rd_ptr_q];

    always_comb begin
        // NOTE: every next-state signal gets its default first, so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (enq_fire)   wr_ptr_d = ~wr_ptr_q;
        if (deq_fire_o) rd_ptr_d = ~rd_ptr_q;
        case ({enq_fire, deq_fire_o})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: storage is reset deliberately because the head entry is the visible send_msg.
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            // NOTE: state registers use non-blocking assignments so all of them update together.
            if (enq_fire) mem_q[wr_ptr_q] <= enq_msg_i;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/crossbar_nxm_buffered.sv
// N_INPUTS x N_OUTPUTS val/rdy crossbar with broadcast and a 2-entry FIFO per output.
// Define XBAR_PERF_CNT_EN to add saturating per-output send-handshake counters (xfer_cnt).
module crossbar_nxm_buffered
    import crossbar_pkg::*;
#(
    parameter  int BIT_WIDTH         = 32,
    parameter  int N_INPUTS          = 4,
    parameter  int N_OUTPUTS         = 4,
    localparam int SEL_W             = $clog2(N_INPUTS),
    localparam int CONTROL_BIT_WIDTH = N_OUTPUTS * (SEL_W + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    crossbar_nxm_buffered_if.slave xbar
);
    typedef struct packed {
        logic             en;
        logic [SEL_W-1:0] sel;
    } ctrl_field_t;

    logic [CONTROL_BIT_WIDTH-1:0] ctrl_q, ctrl_d;
    logic                         ctrl_fire;
    ctrl_field_t                  fld       [N_OUTPUTS];
    logic [N_OUTPUTS-1:0]         full, empty, deq_fire, can_take, enq_val;
    logic [BIT_WIDTH-1:0]         enq_msg   [N_OUTPUTS];
    logic [BIT_WIDTH-1:0]         head_msg  [N_OUTPUTS];
    logic [N_OUTPUTS-1:0]         sel_mask  [N_INPUTS];
    logic [N_INPUTS-1:0]          recv_rdy_w;

    // A route change is only taken with every FIFO empty, so no message straddles two routes.
    assign xbar.control_rdy = &empty;
    assign ctrl_fire        = xbar.control_val && xbar.control_rdy;
    assign ctrl_d           = ctrl_fire ? xbar.control : ctrl_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ctrl_q <= '0;
        else        ctrl_q <= ctrl_d;
    end

    for (genvar k = 0; k < N_OUTPUTS; k++) begin : g_out
        assign fld[k]      = ctrl_q[ctrl_field_lsb(k, N_OUTPUTS, SEL_W) +: SEL_W + 1];
        assign can_take[k] = !full[k] || deq_fire[k];

        xbar_out_fifo2 #(.W(BIT_WIDTH)) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .enq_val_i (enq_val[k]),
            .enq_msg_i (enq_msg[k]),
            .deq_rdy_i (xbar.send_rdy[k]),
            .deq_msg_o (head_msg[k]),
            .full_o    (full[k]),
            .empty_o   (empty[k]),
            .deq_fire_o(deq_fire[k])
        );
    end

    assign xbar.send_msg = head_msg;
    assign xbar.send_val = ~empty;
    assign xbar.recv_rdy = recv_rdy_w;

    // An input is ready only if every output selecting it can take a message this cycle.
    always_comb begin
        sel_mask   = '{default: '0};
        recv_rdy_w = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            for (int k = 0; k < N_OUTPUTS; k++) begin
                sel_mask[i][k] = fld[k].en && (int'(fld[k].sel) == i);
            end
            recv_rdy_w[i] = (|sel_mask[i]) && ((sel_mask[i] & ~can_take) == '0) && !ctrl_fire;
        end
    end

    // All-or-nothing fork: each selecting output enqueues on its input's handshake.
    always_comb begin
        enq_val = '0;
        enq_msg = '{default: '0};
        for (int k = 0; k < N_OUTPUTS; k++) begin
            for (int i = 0; i < N_INPUTS; i++) begin
                if (sel_mask[i][k]) begin
                    enq_val[k] = xbar.recv_val[i] && recv_rdy_w[i];
                    enq_msg[k] = xbar.recv_msg[i];
                end
            end
        end
    end

`ifdef XBAR_PERF_CNT_EN
    xfer_cnt_t cnt_q [N_OUTPUTS];
    xfer_cnt_t cnt_d [N_OUTPUTS];

    always_comb begin
        for (int k = 0; k < N_OUTPUTS; k++) begin
            cnt_d[k] = cnt_q[k];
            if (ctrl_fire)                          cnt_d[k] = '0;
            else if (deq_fire[k] && cnt_q[k] != '1) cnt_d[k] = cnt_q[k] + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '{default: '0};
        else        cnt_q <= cnt_d;
    end

    assign xbar.xfer_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_crossbar_nxm_buffered.sv
// Directed bench for crossbar_nxm_buffered with per-output scoreboard queues.
// Expected route, occupancy and ready values come from the bench's own model.
module tb_crossbar_nxm_buffered;
    localparam int BW = 32;
    localparam int NI = 4;
    localparam int NO = 4;
    localparam int SW = 2;
    localparam int CW = NO * (SW + 1);

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    crossbar_nxm_buffered_if #(.BIT_WIDTH(BW), .N_INPUTS(NI), .N_OUTPUTS(NO)) ifc ();

    crossbar_nxm_buffered #(.BIT_WIDTH(BW), .N_INPUTS(NI), .N_OUTPUTS(NO)) dut (
        .clk  (clk),
        .reset(reset),
        .xbar (ifc)
    );

    int checks = 0;
    int failures = 0;
    logic [BW-1:0] q [NO][$];
    logic [CW-1:0] m_ctrl = '0;
    int accepted [NI];
    int dlv [NO];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model decode: output k's field is shifted down from the top of the word.
    function automatic bit m_selects(input int k, input int i);
        logic [CW-1:0] f;
        f = m_ctrl >> ((NO - 1 - k) * (SW + 1));
        return f[SW] && (int'(f[SW-1:0]) == i);
    endfunction

    task automatic clear_counts();
        for (int i = 0; i < NI; i++) accepted[i] = 0;
        for (int k = 0; k < NO; k++) dlv[k] = 0;
    endtask

    // One clock cycle: compare at the falling edge, update the model, step past the rising edge.
    task automatic tick();
        logic [NI-1:0] exp_rdy;
        logic [NO-1:0] exp_sval;
        bit all_empty, cfire, any, ok;
        @(negedge clk);
        all_empty = 1'b1;
        for (int k = 0; k < NO; k++) if (q[k].size() != 0) all_empty = 1'b0;
        cfire = ifc.control_val && all_empty;
        check("control_rdy", ifc.control_rdy, all_empty);
        for (int k = 0; k < NO; k++) exp_sval[k] = (q[k].size() > 0);
        check("send_val", ifc.send_val, exp_sval);
        for (int k = 0; k < NO; k++)
            if (exp_sval[k]) check($sformatf("send_msg[%0d]", k), ifc.send_msg[k], q[k][0]);
        for (int i = 0; i < NI; i++) begin
            any = 1'b0;
            ok  = 1'b1;
            for (int k = 0; k < NO; k++) begin
                if (m_selects(k, i)) begin
                    any = 1'b1;
                    if (!(q[k].size() < 2 || (exp_sval[k] && ifc.send_rdy[k]))) ok = 1'b0;
                end
            end
            exp_rdy[i] = any && ok && !cfire;
        end
        check("recv_rdy", ifc.recv_rdy, exp_rdy);
        for (int k = 0; k < NO; k++) begin
            if (exp_sval[k] && ifc.send_rdy[k]) begin
                void'(q[k].pop_front());
                dlv[k]++;
            end
        end
        for (int i = 0; i < NI; i++) begin
            if (ifc.recv_val[i] && exp_rdy[i]) begin
                accepted[i]++;
                for (int k = 0; k < NO; k++) if (m_selects(k, i)) q[k].push_back(ifc.recv_msg[i]);
            end
        end
        if (cfire) m_ctrl = ifc.control;
        @(posedge clk);
        #1;
    endtask

    task automatic fire_control(input logic [CW-1:0] word);
        ifc.control     = word;
        ifc.control_val = 1'b1;
        ifc.recv_val    = '0;
        tick();
        ifc.control_val = 1'b0;
    endtask

    task automatic drive_msgs(input logic [BW-1:0] base);
        for (int i = 0; i < NI; i++) ifc.recv_msg[i] = base + BW'(i);
    endtask

    initial begin
        ifc.recv_val    = '0;
        ifc.send_rdy    = '0;
        ifc.control     = '0;
        ifc.control_val = 1'b0;
        drive_msgs('0);
        clear_counts();

        // Out of reset: nothing valid, control ready, no input ready.
        tick();
        tick();
        for (int k = 0; k < NO; k++) check($sformatf("reset_send_msg[%0d]", k), ifc.send_msg[k], '0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // All outputs disabled: no input is ever accepted.
        ifc.recv_val = '1;
        ifc.send_rdy = '1;
        drive_msgs(32'hA0);
        repeat (3) tick();
        check("disabled_accepts", accepted[0] + accepted[1] + accepted[2] + accepted[3], 0);

        // Identity route, sustained full-rate traffic.
        fire_control(12'h977);
        clear_counts();
        for (int c = 0; c < 8; c++) begin
            drive_msgs(32'hA0 + BW'(c << 8));
            ifc.recv_val = '1;
            tick();
        end
        ifc.recv_val = '0;
        repeat (2) tick();
        for (int i = 0; i < NI; i++) check($sformatf("identity_acc[%0d]", i), accepted[i], 8);
        for (int k = 0; k < NO; k++) check($sformatf("identity_dlv[%0d]", k), dlv[k], 8);

        // Broadcast from input 2 with output 3 stalled.
        fire_control(12'hDB6);
        clear_counts();
        ifc.send_rdy = 4'b0111;
        for (int c = 0; c < 5; c++) begin
            ifc.recv_msg[2] = 32'h55 + BW'(c);
            ifc.recv_val    = 4'b0100;
            tick();
        end
        check("bcast_acc", accepted[2], 2);
        ifc.recv_val = '0;
        ifc.send_rdy = '1;
        repeat (3) tick();
        for (int k = 0; k < NO; k++) check($sformatf("bcast_dlv[%0d]", k), dlv[k], 2);

        // Control held off while output 1 buffers a message.
        fire_control(12'h977);
        ifc.send_rdy    = 4'b1101;
        ifc.recv_msg[1] = 32'h77;
        ifc.recv_val    = 4'b0010;
        tick();
        ifc.recv_val    = '0;
        ifc.control     = 12'h924;
        ifc.control_val = 1'b1;
        repeat (2) tick();
        ifc.send_rdy = '1;
        repeat (2) tick();
        ifc.control_val = 1'b0;
        clear_counts();
        drive_msgs(32'hC0);
        ifc.recv_val = 4'b0011;
        tick();
        ifc.recv_val = '0;
        check("new_route_in0", accepted[0], 1);
        check("new_route_in1", accepted[1], 0);
        repeat (2) tick();

        // Full FIFO with simultaneous enqueue and dequeue keeps order.
        clear_counts();
        ifc.send_rdy = '0;
        ifc.recv_val = 4'b0001;
        ifc.recv_msg[0] = 32'h01;
        tick();
        ifc.recv_msg[0] = 32'h02;
        tick();
        ifc.send_rdy    = '1;
        ifc.recv_msg[0] = 32'h03;
        tick();
        ifc.recv_val = '0;
        repeat (3) tick();
        check("full_acc", accepted[0], 3);
        check("full_dlv0", dlv[0], 3);

        // Asynchronous reset in the middle of buffered traffic.
        fire_control(12'h977);
        ifc.send_rdy = '0;
        ifc.recv_val = '1;
        drive_msgs(32'hE0);
        repeat (2) tick();
        #2 reset = 1'b0;
        #1;
        check("rst_send_val", ifc.send_val, '0);
        check("rst_control_rdy", ifc.control_rdy, 1'b1);
        check("rst_recv_rdy", ifc.recv_rdy, '0);
        for (int k = 0; k < NO; k++) check($sformatf("rst_msg[%0d]", k), ifc.send_msg[k], '0);
        for (int k = 0; k < NO; k++) q[k].delete();
        m_ctrl = '0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        clear_counts();
        ifc.send_rdy = '1;
        repeat (3) tick();
        check("post_rst_accepts", accepted[0] + accepted[1] + accepted[2] + accepted[3], 0);
        ifc.recv_val = '0;

`ifdef XBAR_PERF_CNT_EN
        // Counters: ten broadcast transfers, clear on control fire, saturation.
        fire_control(12'h924);
        ifc.recv_msg[0] = 32'h10;
        ifc.recv_val    = 4'b0001;
        repeat (10) tick();
        ifc.recv_val = '0;
        repeat (2) tick();
        check("cnt_out0", ifc.xfer_cnt[0], 10);
        check("cnt_out3", ifc.xfer_cnt[3], 10);
        fire_control(12'h977);
        tick();
        check("cnt_cleared", ifc.xfer_cnt[0], 0);
        ifc.recv_val = 4'b0001;
        repeat (65540) tick();
        ifc.recv_val = '0;
        repeat (2) tick();
        check("cnt_saturated", ifc.xfer_cnt[0], 16'hFFFF);
        check("cnt_idle_out1", ifc.xfer_cnt[1], 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/crossbar_nxm_buffered.md
Name: crossbar_nxm_buffered

Overview:
- Parametrised successor to the single-output crossbar: N_INPUTS x N_OUTPUTS val/rdy crossbar.
- Each output has its own per-output field in a stored control word: an enable bit plus an input select.
- One input may fan out to several outputs (broadcast).
- Each output is decoupled by a 2-entry FIFO, so send_val/send_msg are driven from registers.
- Control is accepted only when all output FIFOs are empty, so a route change never splits or reorders in-flight traffic.

Parameters:
- BIT_WIDTH, 32, message width.
- N_INPUTS, 4, input channels (>=2).
- N_OUTPUTS, 4, output channels (>=1).
- SEL_W, $clog2(N_INPUTS), select field width (derived; do not override).
- CONTROL_BIT_WIDTH, N_OUTPUTS*(SEL_W+1), control word width (derived).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- recv_msg  in  BIT_WIDTH x N_INPUTS  input messages (unpacked array).
- recv_val  in  1 x N_INPUTS  input valid.
- recv_rdy  out  1 x N_INPUTS  input ready.
- send_msg  out  BIT_WIDTH x N_OUTPUTS  output messages (FIFO head).
- send_val  out  1 x N_OUTPUTS  output valid.
- send_rdy  in  1 x N_OUTPUTS  output ready.
- control  in  CONTROL_BIT_WIDTH  routing word.
- control_val  in  1  control valid.
- control_rdy  out  1  control ready.

Behaviour:
- Control field layout:
  - Output k's field is {en_k, sel_k}, SEL_W+1 bits.
  - Output 0 occupies the MSBs; output k field = control[CW-1-k*(SEL_W+1) -: SEL_W+1].
- Reset (reset==0, async): stored control = 0 (all outputs disabled), all FIFOs empty.
  - Reset values: send_val=0, send_msg=0, recv_rdy=0, control_rdy=1.
- control_rdy = 1 iff every output FIFO is empty.
  - Control fires on control_val && control_rdy; the new word takes effect the next cycle.
  - In the cycle control fires, recv_rdy is forced to 0 for all inputs, so no enqueue can use the old route.
- Input i has a selecting set S_i = {k : en_k && sel_k==i}.
  - recv_rdy[i] = (S_i nonempty) && every FIFO k in S_i is not full (occupancy<2 OR dequeuing this cycle) && !control fire.
  - An input with S_i empty, or with sel_k >= N_INPUTS, gets recv_rdy=0.
- Input transfer on recv_val[i] && recv_rdy[i]: recv_msg[i] is enqueued into every FIFO k in S_i in the same cycle (all-or-nothing fork).
- Output FIFO:
  - 2 entries; send_val[k] = not empty; send_msg[k] = head entry.
  - Dequeue on send_val && send_rdy.
  - Latency input->output is 1 cycle: a message enqueued in cycle t is visible at send in cycle t+1.
  - Throughput is 1 message/cycle per output when send_rdy is held high.
- Boundary cases:
  - Simultaneous enqueue+dequeue when full: allowed, occupancy stays 2.
  - Enqueue+dequeue when empty: occupancy goes 0->1.
  - Dequeue when empty: cannot occur, since send_val=0.
  - Pointer wrap is mod 2.
- No combinational path from recv_val to send_val.
  - recv_rdy depends combinationally on send_rdy of its selected outputs: one-level path, permitted.
- Reset asserted mid-transfer: all FIFO contents are discarded and the route is cleared to disabled.

Optional Feature:
- Macro: XBAR_PERF_CNT_EN.
- Defined:
  - Adds output port xfer_cnt, 16 x N_OUTPUTS.
  - One saturating counter per output, incremented on each send handshake; holds at 16'hFFFF.
  - Cleared by reset and on every control fire.
- Undefined: port and counters absent; behaviour otherwise identical.

Decomposition:
- Package crossbar_pkg:
  - Localparam helpers for field width/offset (ctrl_field_lsb(k)).
  - A typedef for the per-output control field struct {logic en; logic [SEL_W-1:0] sel;}.
  - Counter width constant XBAR_CNT_W=16.
- Sub-module: xbar_out_fifo2, a 2-entry val/rdy FIFO with async active-low reset.
  - Exposes full/empty and deq_fire; instantiated N_OUTPUTS times.
- Crossbar top holds the control register, the fork-ready logic, and the optional counters.

Test Plan:
- Reset with reset=0 mid-stream -> send_val all 0, control_rdy=1, recv_rdy all 0.
  - Then control all-disabled -> no input ever accepted.
- N=4,M=4; control {1,0},{1,1},{1,2},{1,3}; each input drives 0xA0+i, send_rdy=1.
  - -> each output k receives 0xA0+k one cycle after acceptance; 1 msg/cycle sustained.
- Broadcast: all outputs sel=2, input 2 sends 0x55 with send_rdy[3]=0.
  - -> FIFO3 fills after 2 messages.
  - -> recv_rdy[2] drops; all four outputs receive exactly the same two messages, in order.
- Control while traffic buffered: FIFO1 holds 1 entry, control_val=1 -> control_rdy=0, route unchanged.
  - After the drain: accepted next cycle, new route effective the following cycle.
- Full FIFO with simultaneous enq+deq: occupancy stays 2 and order is preserved.
  - e.g. 0x01,0x02,0x03 in -> 0x01,0x02,0x03 out.
- With XBAR_PERF_CNT_EN: 10 transfers on output 0 -> xfer_cnt[0]=10.
  - A control fire then clears it to 0.
  - A forced count of 0xFFFF plus 1 more transfer -> stays 0xFFFF.
